// File: rtl/ps_maxlen_cutter.sv
// rtl/ps_maxlen_cutter.sv - PacketStream stage that truncates packets longer than maxlen words
// Zero-latency data path; only framing state, the latched limit and cut statistics are registered.
module ps_maxlen_cutter #(
  parameter int WIDTH    = 8,
  parameter int LENWIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LENWIDTH-1:0] maxlen,
  input  logic                cnt_clr,
  input  logic [WIDTH-1:0]    i_dat,
  input  logic                i_val,
  input  logic                i_eop,
  output logic                i_rdy,
  output logic [WIDTH-1:0]    o_dat,
  output logic                o_val,
  output logic                o_eop,
  input  logic                o_rdy,
  output logic                cut_pulse,
  output logic [LENWIDTH-1:0] cut_cnt
);

  typedef enum logic {PASS = 1'b0, DISCARD = 1'b1} state_t;

  state_t              st, st_nxt;
  logic                sop_reg, sop_nxt;
  logic [LENWIDTH-1:0] wcnt, wcnt_nxt;
  logic [LENWIDTH-1:0] lim_reg, lim;
  logic                last_allowed;
  logic                lim_load;
  logic                cut;

  // The limit is sampled with the first word so mid-packet maxlen changes are ignored.
  assign lim          = sop_reg ? maxlen : lim_reg;
  assign last_allowed = (lim != '0) && (wcnt == lim - LENWIDTH'(1));
  assign o_dat        = i_dat;

  always_comb begin
    st_nxt   = st;
    sop_nxt  = sop_reg;
    wcnt_nxt = wcnt;
    lim_load = 1'b0;
    cut      = 1'b0;
    o_val    = i_val;
    o_eop    = i_eop | last_allowed;
    i_rdy    = o_rdy;
    case (st)
      PASS: begin
        if (i_val && o_rdy) begin
          lim_load = sop_reg;
          if (i_eop) begin
            sop_nxt  = 1'b1;
            wcnt_nxt = '0;
          end else if (last_allowed) begin
            st_nxt  = DISCARD;
            sop_nxt = 1'b0;
            cut     = 1'b1;
          end else begin
            sop_nxt  = 1'b0;
            wcnt_nxt = (wcnt == '1) ? wcnt : wcnt + LENWIDTH'(1);
          end
        end
      end
      DISCARD: begin
        // Drain the tail of a cut packet without waiting on the sink.
        o_val = 1'b0;
        o_eop = 1'b0;
        i_rdy = 1'b1;
        if (i_val && i_eop) begin
          st_nxt   = PASS;
          sop_nxt  = 1'b1;
          wcnt_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= PASS;
      sop_reg   <= 1'b1;
      wcnt      <= '0;
      lim_reg   <= '0;
      cut_pulse <= 1'b0;
      cut_cnt   <= '0;
    end else begin
      st        <= st_nxt;
      sop_reg   <= sop_nxt;
      wcnt      <= wcnt_nxt;
      cut_pulse <= cut;
      if (lim_load) lim_reg <= maxlen;
      if (cnt_clr) cut_cnt <= cut ? LENWIDTH'(1) : '0;
      else if (cut && (cut_cnt != '1)) cut_cnt <= cut_cnt + LENWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ps_maxlen_cutter.sv
// tb/tb_ps_maxlen_cutter.sv - bench for ps_maxlen_cutter
// Packet-level reference model on two instances (LENWIDTH 16 and 2), vector table, random traffic.
module tb_ps_maxlen_cutter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_maxlen = 16'd4;
  logic        a_clr = 1'b0;
  logic [7:0]  a_dat = 8'd0;
  logic        a_val = 1'b0, a_eop = 1'b0, a_irdy;
  logic [7:0]  a_odat;
  logic        a_oval, a_oeop, a_ordy = 1'b1, a_pulse;
  logic [15:0] a_cnt;

  logic [1:0]  b_maxlen = 2'd1;
  logic        b_clr = 1'b0;
  logic [7:0]  b_dat = 8'd0;
  logic        b_val = 1'b0, b_eop = 1'b0, b_irdy;
  logic [7:0]  b_odat;
  logic        b_oval, b_oeop, b_ordy = 1'b1, b_pulse;
  logic [1:0]  b_cnt;

  ps_maxlen_cutter #(.WIDTH(8), .LENWIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .maxlen(a_maxlen), .cnt_clr(a_clr),
    .i_dat(a_dat), .i_val(a_val), .i_eop(a_eop), .i_rdy(a_irdy),
    .o_dat(a_odat), .o_val(a_oval), .o_eop(a_oeop), .o_rdy(a_ordy),
    .cut_pulse(a_pulse), .cut_cnt(a_cnt));

  ps_maxlen_cutter #(.WIDTH(8), .LENWIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .maxlen(b_maxlen), .cnt_clr(b_clr),
    .i_dat(b_dat), .i_val(b_val), .i_eop(b_eop), .i_rdy(b_irdy),
    .o_dat(b_odat), .o_val(b_oval), .o_eop(b_oeop), .o_rdy(b_ordy),
    .cut_pulse(b_pulse), .cut_cnt(b_cnt));

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;
  bit rnd_gaps = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word index within the packet and the limit sampled at its first word.
  int idx[2] = '{0, 0};
  int lim_m[2] = '{0, 0};
  int cnt_m[2] = '{0, 0};
  bit pend[2] = '{1'b0, 1'b0};

  task automatic model_step(input int k, input string nm, input bit rst, input int maxl,
                            input bit clr, input int idat, input bit ival, input bit ieop,
                            input bit irdy, input int odat, input bit oval, input bit oeop,
                            input bit ordy, input bit pulse, input int cnt, input int cmax);
    int cl;
    bit disc, last, acc, cut;
    cl   = (idx[k] == 0) ? maxl : lim_m[k];
    disc = (cl != 0) && (idx[k] >= cl);
    last = (cl != 0) && (idx[k] == cl - 1);
    if (disc) begin
      chk({nm, ".disc_i_rdy"}, irdy, 1);
      chk({nm, ".disc_o_val"}, oval, 0);
      chk({nm, ".disc_o_eop"}, oeop, 0);
    end else begin
      chk({nm, ".i_rdy"}, irdy, ordy);
      chk({nm, ".o_val"}, oval, ival);
      chk({nm, ".o_eop"}, oeop, ieop || last);
      if (ival) chk({nm, ".o_dat"}, odat, idat);
    end
    chk({nm, ".cut_pulse"}, pulse, pend[k]);
    chk({nm, ".cut_cnt"}, cnt, cnt_m[k]);
    if (rst) begin
      idx[k] = 0; lim_m[k] = 0; cnt_m[k] = 0; pend[k] = 1'b0;
    end else begin
      acc = ival && (disc || ordy);
      cut = acc && !disc && last && !ieop;
      if (acc) begin
        if (idx[k] == 0) lim_m[k] = maxl;
        idx[k] = ieop ? 0 : idx[k] + 1;
      end
      pend[k] = cut;
      if (clr) cnt_m[k] = cut ? 1 : 0;
      else if (cut && cnt_m[k] < cmax) cnt_m[k]++;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, "a", reset, int'(a_maxlen), a_clr, int'(a_dat), a_val, a_eop, a_irdy,
               int'(a_odat), a_oval, a_oeop, a_ordy, a_pulse, int'(a_cnt), 65535);
    model_step(1, "b", reset, int'(b_maxlen), b_clr, int'(b_dat), b_val, b_eop, b_irdy,
               int'(b_odat), b_oval, b_oeop, b_ordy, b_pulse, int'(b_cnt), 3);
  end

  task automatic idle(input int n);
    a_val = 1'b0; a_eop = 1'b0; a_clr = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends len words on instance a; optionally changes maxlen after word chg_at is accepted.
  task automatic send_pkt(input int len, input int base, input bit with_eop,
                          input int chg_at, input int chg_val);
    for (int k = 0; k < len; k++) begin
      int guard;
      bit acc;
      guard = 0;
      acc = 1'b0;
      if (rnd_gaps && ($urandom % 4 == 0)) begin
        a_val = 1'b0; a_eop = 1'b0;
        @(posedge clk); #1;
      end
      a_val = 1'b1;
      a_dat = 8'(base + k);
      a_eop = with_eop && (k == len - 1);
      while (!acc) begin
        case (rdy_mode)
          0:       a_ordy = 1'b1;
          1:       a_ordy = ~a_ordy;
          default: a_ordy = 1'($urandom % 2);
        endcase
        a_clr = (rdy_mode == 2) && ($urandom % 16 == 0);
        @(negedge clk); #1;
        acc = a_irdy;
        @(posedge clk); #1;
        guard++;
        if (guard > 200) begin
          chk("drv_timeout", 0, 1);
          break;
        end
      end
      if (k == chg_at) a_maxlen = 16'(chg_val);
    end
    a_val = 1'b0; a_eop = 1'b0; a_clr = 1'b0;
  endtask

  typedef struct {
    logic       val, eop, clr;
    logic       xval, xeop, xrdy, xpulse;
    logic [1:0] xcnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int cs[17] = '{0, 1, 1, 2, 2, 3, 3, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3};
    // Two-word packets with maxlen=1 and LENWIDTH=2; clear lands on the 4th cut.
    for (int c = 0; c < 16; c++) begin
      logic w;
      w = 1'(c % 2);
      tbl[c] = '{1'b1, w, (c == 6), ~w, ~w, 1'b1, w, 2'(cs[c])};
    end
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'(cs[16])};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_cut_cnt", a_cnt, 0);
    chk("reset_cut_pulse", a_pulse, 0);
    chk("reset_i_rdy", a_irdy, 1);

    a_maxlen = 16'd4;
    send_pkt(3, 'h10, 1'b1, -1, 0);
    idle(2);
    chk("t1_cut_cnt", a_cnt, 0);

    send_pkt(7, 'h20, 1'b1, -1, 0);
    idle(2);
    chk("t2_cut_cnt", a_cnt, 1);
    send_pkt(3, 'h30, 1'b1, -1, 0);

    send_pkt(4, 'h40, 1'b1, -1, 0);
    idle(1);
    chk("t3_exact_cut_cnt", a_cnt, 1);
    a_maxlen = 16'd0;
    send_pkt(100, 0, 1'b1, -1, 0);
    idle(1);
    chk("t3_unlimited_cut_cnt", a_cnt, 1);

    a_maxlen = 16'd3;
    rdy_mode = 1;
    send_pkt(6, 'h50, 1'b1, 0, 10);
    rdy_mode = 0;
    a_ordy = 1'b1;
    idle(2);
    chk("t4_cut_cnt", a_cnt, 2);

    a_maxlen = 16'd3;
    send_pkt(5, 'h60, 1'b0, -1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_cut_cnt_after_reset", a_cnt, 0);
    chk("t5_cut_pulse_after_reset", a_pulse, 0);
    send_pkt(2, 'h70, 1'b1, -1, 0);
    idle(2);
    chk("t5_cut_cnt", a_cnt, 0);

    for (int c = 0; c < 17; c++) begin
      b_maxlen = 2'd1;
      b_ordy = 1'b1;
      b_val = tbl[c].val;
      b_eop = tbl[c].eop;
      b_clr = tbl[c].clr;
      b_dat = 8'(8'h80 + c);
      @(negedge clk); #1;
      chk($sformatf("t6[%0d].o_val", c), b_oval, tbl[c].xval);
      chk($sformatf("t6[%0d].o_eop", c), b_oeop, tbl[c].xeop);
      chk($sformatf("t6[%0d].i_rdy", c), b_irdy, tbl[c].xrdy);
      chk($sformatf("t6[%0d].cut_pulse", c), b_pulse, tbl[c].xpulse);
      chk($sformatf("t6[%0d].cut_cnt", c), b_cnt, tbl[c].xcnt);
      if (tbl[c].xval) chk($sformatf("t6[%0d].o_dat", c), b_odat, 8'h80 + c);
      @(posedge clk); #1;
    end
    b_val = 1'b0; b_eop = 1'b0; b_clr = 1'b0;

    rdy_mode = 2;
    rnd_gaps = 1'b1;
    for (int p = 0; p < 300; p++) begin
      a_maxlen = 16'($urandom % 7);
      send_pkt(1 + int'($urandom % 12), int'($urandom % 256), 1'b1,
               ($urandom % 4 == 0) ? int'($urandom % 3) : -1, int'($urandom % 7));
    end
    rdy_mode = 0;
    a_ordy = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps_maxlen_cutter.md
Name: ps_maxlen_cutter

Overview:
PacketStream stage that enforces a maximum packet length in words, placed directly downstream of the traffic on/off switch stage. Packets no longer than the limit pass unchanged. Longer packets are cut: the limit-th word is forced to carry end-of-packet, and the rest of the input packet is consumed and discarded. The data path is zero-latency. Only the framing state is registered. Cut events are reported as a pulse and in a saturating counter.

Parameters:
WIDTH, 8, data word width
LENWIDTH, 16, width of the length limit, the word counter and the cut-event counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset (clk is the only clock; reset is sampled on the rising edge of clk)
maxlen  input  LENWIDTH  maximum packet length in words; 0 = unlimited
cnt_clr  input  1  synchronous clear of cut_cnt
i_dat  input  WIDTH  input data
i_val  input  1  input word valid
i_eop  input  1  input end of packet
i_rdy  output  1  input ready
o_dat  output  WIDTH  output data
o_val  output  1  output word valid
o_eop  output  1  output end of packet
o_rdy  input  1  output ready
cut_pulse  output  1  one-cycle pulse, registered, one per truncated packet
cut_cnt  output  LENWIDTH  number of truncated packets, saturating

Behaviour:
- Handshake: a word transfers on a clk edge when val & rdy. i_dat/i_val/i_eop are held stable while not accepted.
- State: sop_reg (next word is first of a packet; reset 1), st in {PASS, DISCARD} (reset PASS), wcnt (words already accepted in current packet; reset 0), lim_reg (reset 0).
- Effective limit: lim = sop_reg ? maxlen : lim_reg. On acceptance of a first word, lim_reg <= maxlen. maxlen changes mid-packet have no effect on that packet.
- last_allowed = (lim != 0) & (wcnt == lim - 1).
- PASS outputs: o_dat = i_dat; o_val = i_val; i_rdy = o_rdy; o_eop = i_eop | last_allowed.
- PASS transitions on accepted word:
  - If i_eop: sop_reg <= 1, wcnt <= 0, stay PASS.
  - Else if last_allowed: this is a cut. st <= DISCARD, sop_reg <= 0, cut event.
  - Else: wcnt <= wcnt + 1, saturating at all-ones (unlimited mode must never wrap), sop_reg <= 0.
- DISCARD outputs: o_val = 0, o_eop = 0, i_rdy = 1 (input drained regardless of o_rdy), o_dat = i_dat (don't care).
- DISCARD transitions: on an accepted word with i_eop, st <= PASS, sop_reg <= 1, wcnt <= 0. Otherwise stay.
- A packet whose natural eop falls exactly on the limit word is not a cut: no pulse, no DISCARD.
- lim = 1: every packet's first word carries o_eop. A single-word input packet is not counted as a cut.
- Cut event: cut_pulse = 1 for exactly the cycle after the accepting edge. cut_cnt increments, saturating at 2^LENWIDTH-1.
- cnt_clr: cut_cnt <= 0. If cnt_clr and a cut event occur on the same edge, cut_cnt <= 1.
- Reset (synchronous, any state including mid-packet or DISCARD) restores all reset values: st = PASS, sop_reg = 1, wcnt = 0, lim_reg = 0, cut_pulse = 0, cut_cnt = 0. During reset the combinational outputs follow PASS equations from the reset state.
- No bubbles: throughput is one word per cycle when i_val and o_rdy are continuously high, including the PASS→DISCARD→PASS transitions.

Test Plan:
1. maxlen=4, 3-word packet A,B,C (eop on C), o_rdy=1 → 3 output words, eop on C only, cut_pulse stays 0, cut_cnt=0.
2. maxlen=4, 7-word packet W0..W6 → outputs W0..W3 with o_eop on W3. W4..W6 accepted with i_rdy=1 and o_val=0. cut_pulse high one cycle after W3's acceptance edge. cut_cnt=1. Next packet passes intact.
3. maxlen=4, exact 4-word packet → eop on word 4 only, no pulse, cut_cnt unchanged. Then maxlen=0 with a 100-word packet → all 100 words forwarded, no cut.
4. maxlen=3, 6-word packet, o_rdy toggling 1/0 every cycle, with maxlen changed to 10 after word 1 → cut still at word 3 (value latched). Discard phase completes while o_rdy=0. Data integrity is preserved under stalls.
5. Assert reset for one cycle while in DISCARD mid-packet, then send a new 2-word packet → both words forwarded with eop on word 2, cut_cnt=0, cut_pulse=0.
6. LENWIDTH=2, maxlen=1, four back-to-back 2-word packets, with cnt_clr asserted on the edge of the 4th cut → cut_cnt sequence 1,2,3,1. A final 2-word packet with no clear → cut_cnt=2. Then three more cut packets → cut_cnt saturates at 3.
